lsq_retire_decide: RTL and testbench

LSQ_RETIRE_DECIDE -- requirements
Module: lsq_retire_decide

---
 rtl/lsq_retire_decide.sv | 198 +++++++++++++++++++
 tb/tb_lsq_retire_decide.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_retire_decide.sv
// LSQ retire decode: maps per-lane retire info onto retire slots and queues the
// decoded bundles in a small in-order FIFO that supports per-thread flush with compaction.
module lsq_retire_decide #(
    parameter int LANES = 6,
    parameter int SLOTS = 10,
    parameter int IIW   = 6,
    parameter int EXW   = 4,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IIW-1:0]          in_ii,
    input  logic                    in_thread,
    input  logic [LANES-1:0]        in_ret_mask,
    input  logic [LANES*4-1:0]      in_slot,
    input  logic [LANES-1:0]        in_excpt,
    input  logic [LANES-1:0]        in_ldconfl,
    input  logic [LANES-1:0]        in_waitconfl,
    input  logic [LANES*EXW-1:0]    in_exbits,
    input  logic [IIW-1:0]          cntrl_ii,
    input  logic                    do_retire,
    input  logic                    except,
    input  logic                    except_thread,
    output logic                    out_valid,
    output logic [IIW-1:0]          out_ii,
    output logic                    out_thread,
    output logic [SLOTS-1:0]        out_en,
    output logic [SLOTS-1:0]        out_fine,
    output logic [SLOTS-1:0]        out_ldconfl,
    output logic [SLOTS-1:0]        out_waitconfl,
    output logic [SLOTS-1:0]        out_except,
    output logic [SLOTS*EXW-1:0]    out_exbits,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                    err_slot
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [IIW-1:0]       ii;
        logic                 thread;
        logic [SLOTS-1:0]     en;
        logic [SLOTS-1:0]     fine;
        logic [SLOTS-1:0]     ldconfl;
        logic [SLOTS-1:0]     waitconfl;
        logic [SLOTS-1:0]     excpt;
        logic [SLOTS*EXW-1:0] exbits;
    } entry_t;

    logic [SLOTS-1:0]     dec_en;
    logic [SLOTS-1:0]     dec_ex;
    logic [SLOTS-1:0]     dec_ld;
    logic [SLOTS-1:0]     dec_wt;
    logic [SLOTS*EXW-1:0] dec_exbits;
    logic                 bad_any;
    entry_t               entry_in;

    entry_t               mem [DEPTH];
    entry_t               mem_compact [DEPTH];
    entry_t               head;
    logic [PW-1:0]        rd_ptr_reg;
    logic [PW-1:0]        wr_ptr_reg;
    logic [CW-1:0]        count_reg;
    logic                 err_slot_reg;

    logic                 flush_head;
    logic                 head_match;
    logic                 pop;
    logic                 push;
    int                   rd_base;
    int                   keep_n;
    int                   src_idx;
    int                   dst_idx;
    int                   wr_flush;

    // Slot-centric decode: each slot ORs in every lane that targets it.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic           s_en, s_ex, s_ld, s_wt;
            logic [EXW-1:0] s_exb;
            always_comb begin
                s_en  = 1'b0;
                s_ex  = 1'b0;
                s_ld  = 1'b0;
                s_wt  = 1'b0;
                s_exb = '0;
                for (int i = 0; i < LANES; i++) begin
                    if (in_ret_mask[i] && int'(in_slot[i*4 +: 4]) == gi) begin
                        s_en  = 1'b1;
                        s_ex  = s_ex | in_excpt[i];
                        s_ld  = s_ld | in_ldconfl[i];
                        s_wt  = s_wt | in_waitconfl[i];
                        s_exb = s_exb | in_exbits[i*EXW +: EXW];
                    end
                end
            end
            assign dec_en[gi] = s_en;
            assign dec_ex[gi] = s_ex;
            assign dec_ld[gi] = s_ld;
            assign dec_wt[gi] = s_wt;
            assign dec_exbits[gi*EXW +: EXW] = s_exb;
        end
    endgenerate

    always_comb begin
        bad_any = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (in_ret_mask[i] && int'(in_slot[i*4 +: 4]) >= SLOTS) begin
                bad_any = 1'b1;
            end
        end
    end

    assign entry_in = {in_ii, in_thread, dec_en, dec_en & ~dec_ex & ~dec_ld & ~dec_wt,
                       dec_ld, dec_wt, dec_ex, dec_exbits};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign head       = mem[rd_ptr_reg];
    assign out_valid  = (count_reg != '0);
    assign head_match = out_valid && (cntrl_ii == head.ii);
    assign flush_head = except & out_valid & (head.thread == except_thread);
    assign pop        = out_valid & do_retire & (cntrl_ii == head.ii) & ~flush_head;
    assign in_ready   = ~rst & ~stall & ~except & ((int'(count_reg) < DEPTH) | pop);
    assign push       = in_valid & in_ready;

    // Flush rebuild: survivors (after an optional head pop) are repacked in order
    // starting at the new read pointer. Reads come from the old array, so in-place is safe.
    always_comb begin
        mem_compact = mem;
        keep_n      = 0;
        src_idx     = 0;
        dst_idx     = 0;
        rd_base     = int'(rd_ptr_reg) + (pop ? 1 : 0);
        if (rd_base >= DEPTH) rd_base = rd_base - DEPTH;
        for (int j = 0; j < DEPTH; j++) begin
            src_idx = int'(rd_ptr_reg) + j;
            if (src_idx >= DEPTH) src_idx = src_idx - DEPTH;
            if (j < int'(count_reg) && !(j == 0 && pop) &&
                mem[PW'(src_idx)].thread != except_thread) begin
                dst_idx = rd_base + keep_n;
                if (dst_idx >= DEPTH) dst_idx = dst_idx - DEPTH;
                mem_compact[PW'(dst_idx)] = mem[PW'(src_idx)];
                keep_n = keep_n + 1;
            end
        end
        wr_flush = rd_base + keep_n;
        if (wr_flush >= DEPTH) wr_flush = wr_flush - DEPTH;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (except) begin
                mem <= mem_compact;
            end else if (push) begin
                mem[wr_ptr_reg] <= entry_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            err_slot_reg <= 1'b0;
        end else begin
            if (push && bad_any) err_slot_reg <= 1'b1;
            if (except) begin
                rd_ptr_reg <= PW'(rd_base);
                wr_ptr_reg <= PW'(wr_flush);
                count_reg  <= CW'(keep_n);
            end else begin
                if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                if (push && !pop)      count_reg <= count_reg + 1'b1;
                else if (pop && !push) count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign out_ii        = out_valid ? head.ii : '1;
    assign out_thread    = out_valid & head.thread;
    assign out_en        = head.en & {SLOTS{head_match}};
    assign out_fine      = head.fine & {SLOTS{out_valid}};
    assign out_ldconfl   = head.ldconfl & {SLOTS{out_valid}};
    assign out_waitconfl = head.waitconfl & {SLOTS{out_valid}};
    assign out_except    = head.excpt & {SLOTS{out_valid}};
    assign out_exbits    = head.exbits & {(SLOTS*EXW){out_valid}};
    assign count         = count_reg;
    assign err_slot      = err_slot_reg;
endmodule

// File: tb/tb_lsq_retire_decide.sv
// Bench for lsq_retire_decide: directed scenarios followed by random traffic,
// all checked each cycle against a queue-based reference model.
module tb_lsq_retire_decide;
    localparam int LANES = 6;
    localparam int SLOTS = 10;
    localparam int IIW   = 6;
    localparam int EXW   = 4;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst, stall, in_valid, in_ready, in_thread;
    logic [IIW-1:0] in_ii, cntrl_ii, out_ii;
    logic [LANES-1:0] in_ret_mask, in_excpt, in_ldconfl, in_waitconfl;
    logic [LANES*4-1:0] in_slot;
    logic [LANES*EXW-1:0] in_exbits;
    logic do_retire, except, except_thread, out_valid, out_thread, err_slot;
    logic [SLOTS-1:0] out_en, out_fine, out_ldconfl, out_waitconfl, out_except;
    logic [SLOTS*EXW-1:0] out_exbits;
    logic [1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsq_retire_decide #(.LANES(LANES), .SLOTS(SLOTS), .IIW(IIW), .EXW(EXW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_ready(in_ready),
        .in_ii(in_ii), .in_thread(in_thread), .in_ret_mask(in_ret_mask), .in_slot(in_slot),
        .in_excpt(in_excpt), .in_ldconfl(in_ldconfl), .in_waitconfl(in_waitconfl),
        .in_exbits(in_exbits), .cntrl_ii(cntrl_ii), .do_retire(do_retire), .except(except),
        .except_thread(except_thread), .out_valid(out_valid), .out_ii(out_ii),
        .out_thread(out_thread), .out_en(out_en), .out_fine(out_fine),
        .out_ldconfl(out_ldconfl), .out_waitconfl(out_waitconfl), .out_except(out_except),
        .out_exbits(out_exbits), .count(count), .err_slot(err_slot)
    );

    typedef struct {
        logic [IIW-1:0]       ii;
        logic                 th;
        logic [SLOTS-1:0]     en, fine, ld, wt, ex;
        logic [SLOTS*EXW-1:0] exb;
    } ent_t;

    ent_t q[$];
    logic m_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Lane-driven model decode: each participating lane deposits its flags into its slot.
    function automatic ent_t model_decode(output logic bad);
        ent_t e;
        int s;
        e.ii = in_ii; e.th = in_thread;
        e.en = '0; e.ld = '0; e.wt = '0; e.ex = '0; e.exb = '0;
        bad = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            s = int'(in_slot[i*4 +: 4]);
            if (in_ret_mask[i]) begin
                if (s >= SLOTS) bad = 1'b1;
                else begin
                    e.en[s] = 1'b1;
                    e.ex[s] = e.ex[s] | in_excpt[i];
                    e.ld[s] = e.ld[s] | in_ldconfl[i];
                    e.wt[s] = e.wt[s] | in_waitconfl[i];
                    e.exb[s*EXW +: EXW] = e.exb[s*EXW +: EXW] | in_exbits[i*EXW +: EXW];
                end
            end
        end
        e.fine = e.en & ~e.ex & ~e.ld & ~e.wt;
        return e;
    endfunction

    task automatic idle();
        rst = 0; stall = 0; in_valid = 0; in_ii = '0; in_thread = 0;
        in_ret_mask = '0; in_slot = '0; in_excpt = '0; in_ldconfl = '0; in_waitconfl = '0;
        in_exbits = '0; cntrl_ii = '0; do_retire = 0; except = 0; except_thread = 0;
    endtask

    // One clock: compare all outputs with the model, take the edge, advance the model.
    task automatic cycle(input string tag);
        ent_t h, d;
        logic v, fh, pp, rdy, bad;
        #1;
        v = (q.size() != 0);
        if (v) h = q[0];
        else begin
            h.ii = '1; h.th = 0; h.en = '0; h.fine = '0; h.ld = '0; h.wt = '0; h.ex = '0; h.exb = '0;
        end
        fh  = except && v && (h.th == except_thread);
        pp  = v && do_retire && (cntrl_ii == h.ii) && !fh;
        rdy = !rst && !stall && !except && (q.size() < DEPTH || pp);
        chk({tag, ".in_ready"},  in_ready,  rdy);
        chk({tag, ".out_valid"}, out_valid, v);
        chk({tag, ".out_ii"},    out_ii,    h.ii);
        chk({tag, ".out_thread"}, out_thread, h.th);
        chk({tag, ".out_en"},    out_en,    (v && cntrl_ii == h.ii) ? h.en : '0);
        chk({tag, ".out_fine"},  out_fine,  h.fine);
        chk({tag, ".out_ld"},    out_ldconfl, h.ld);
        chk({tag, ".out_wait"},  out_waitconfl, h.wt);
        chk({tag, ".out_exc"},   out_except, h.ex);
        chk({tag, ".out_exbits"}, out_exbits, h.exb);
        chk({tag, ".count"},     count,     q.size());
        chk({tag, ".err_slot"},  err_slot,  m_err);
        d = model_decode(bad);
        $display("%s: ii=%0d push=%0d pop=%0d flush=%0d cnt=%0d", tag, in_ii,
                 in_valid && rdy, pp, except, q.size());
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (pp) void'(q.pop_front());
            if (except) begin
                for (int k = q.size() - 1; k >= 0; k--)
                    if (q[k].th == except_thread) q.delete(k);
            end
            if (in_valid && rdy) begin
                if (bad) m_err = 1'b1;
                q.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    task automatic push_simple(input logic [IIW-1:0] ii, input logic th);
        idle();
        in_valid = 1; in_ii = ii; in_thread = th;
        in_ret_mask = 6'b000001; in_slot[3:0] = 4'd1;
        cycle("push");
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        q.delete();
        cycle("reset");
        idle();

        // Clean bundle
        in_valid = 1; in_ii = 6'd5; in_ret_mask = 6'b000011;
        in_slot[3:0] = 4'd0; in_slot[7:4] = 4'd3;
        cycle("clean_push");
        idle(); cntrl_ii = 6'd5; do_retire = 1; #1;
        chk("clean.en", out_en, 10'h009);
        chk("clean.fine", out_fine, 10'h009);
        chk("clean.count1", count, 1);
        cycle("clean_pop");
        idle(); #1;
        chk("clean.count0", count, 0);
        chk("clean.ii_empty", out_ii, 6'h3f);

        // Lane merge onto slot 7
        in_valid = 1; in_ii = 6'd9; in_ret_mask = 6'b000101;
        in_slot[3:0] = 4'd7; in_slot[11:8] = 4'd7; in_ldconfl = 6'b000100;
        in_exbits[3:0] = 4'h1; in_exbits[11:8] = 4'h4;
        cycle("merge_push");
        idle(); #1;
        chk("merge.ld7", out_ldconfl[7], 1'b1);
        chk("merge.fine7", out_fine[7], 1'b0);
        chk("merge.exb7", out_exbits[31:28], 4'h5);
        cntrl_ii = 6'd9; do_retire = 1;
        cycle("merge_pop");

        // Full plus simultaneous retire
        push_simple(6'd1, 0);
        push_simple(6'd2, 0);
        idle(); in_valid = 1; in_ii = 6'd3; in_ret_mask = 6'b000001;
        cntrl_ii = 6'd1; do_retire = 1; #1;
        chk("full.ready", in_ready, 1'b1);
        cycle("full_pushpop");
        idle(); #1;
        chk("full.count", count, 2);
        chk("full.head", out_ii, 6'd2);
        cntrl_ii = 6'd2; do_retire = 1;
        cycle("drain2");
        idle(); #1;
        chk("full.next", out_ii, 6'd3);
        cntrl_ii = 6'd3; do_retire = 1;
        cycle("drain3");

        // Thread flush
        push_simple(6'd1, 0);
        push_simple(6'd2, 1);
        idle(); except = 1; except_thread = 0; in_valid = 1; in_ii = 6'd4; #1;
        chk("flush.ready", in_ready, 1'b0);
        cycle("flush");
        idle(); #1;
        chk("flush.head", out_ii, 6'd2);
        chk("flush.count", count, 1);
        cntrl_ii = 6'd2; do_retire = 1;
        cycle("flush_drain");

        // Bad slot on lane 4
        idle(); in_valid = 1; in_ii = 6'd7; in_ret_mask = 6'b010001;
        in_slot[3:0] = 4'd1; in_slot[19:16] = 4'd12;
        cycle("bad_push");
        idle(); cntrl_ii = 6'd7; #1;
        chk("bad.err", err_slot, 1'b1);
        chk("bad.en", out_en, 10'h002);
        do_retire = 1;
        cycle("bad_pop");

        // Reset mid-operation
        push_simple(6'd1, 0);
        push_simple(6'd2, 1);
        idle(); rst = 1; cntrl_ii = 6'd1; do_retire = 1;
        cycle("mid_rst");
        idle(); #1;
        chk("rst.count", count, 0);
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.ii", out_ii, 6'h3f);
        chk("rst.err", err_slot, 1'b0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            rst           = ($urandom_range(0, 99) == 0);
            stall         = ($urandom_range(0, 5) == 0);
            in_valid      = ($urandom_range(0, 3) != 0);
            in_ii         = IIW'($urandom_range(0, 3));
            in_thread     = 1'($urandom);
            in_ret_mask   = LANES'($urandom);
            for (int i = 0; i < LANES; i++) in_slot[i*4 +: 4] = 4'($urandom_range(0, 10));
            in_excpt      = LANES'($urandom) & LANES'($urandom);
            in_ldconfl    = LANES'($urandom) & LANES'($urandom);
            in_waitconfl  = LANES'($urandom) & LANES'($urandom);
            in_exbits     = (LANES*EXW)'($urandom);
            cntrl_ii      = IIW'($urandom_range(0, 3));
            do_retire     = ($urandom_range(0, 3) != 0);
            except        = ($urandom_range(0, 7) == 0);
            except_thread = 1'($urandom);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
